serial_slice_adder_ctrl: RTL
============================

Name: serial_slice_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by feeding 2-bit slices, LSB slice first, through the team's combinational 2-bit full-adder slice (`synth`), one slice per clock.
- Drives the slice's aa1/aa0/bb1/bb0/cc0 inputs and captures its cc1/ss1/ss0 outputs.
- Registers the inter-slice carry and assembles the full WIDTH-bit sum plus carry-out.
- Sits directly upstream and downstream of the slice; the slice is instantiated outside this block.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. NSLICE = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered final carry.
- aa1  output  1  slice operand A bit 1.
- aa0  output  1  slice operand A bit 0.
- bb1  output  1  slice operand B bit 1.
- bb0  output  1  slice operand B bit 0.
- cc0  output  1  slice carry-in.
- cc1  input  1  slice carry-out.
- ss1  input  1  slice sum bit 1.
- ss0  input  1  slice sum bit 0.

Behaviour:
- Reset (rst=1 at an edge) overrides everything, including mid-operation:
  - state <= IDLE; busy, done, sum, cout, slice index and carry register all cleared to 0.
  - Slice drive outputs are 0 while in IDLE.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Latch a, b; carry_reg <= cin; idx <= 0; state <= RUN.
  - busy rises in the next cycle. start=0: remain in IDLE.
- RUN, combinational drive each cycle:
  - {aa1,aa0} = A_lat[2*idx+1 : 2*idx].
  - {bb1,bb0} = B_lat[2*idx+1 : 2*idx].
  - cc0 = carry_reg.
- RUN, at each edge:
  - acc[2*idx+1 : 2*idx] <= {ss1,ss0}; carry_reg <= cc1.
  - If idx == NSLICE-1: sum <= assembled acc including the current slice, cout <= cc1, state <= DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, busy=1, slice drive outputs 0; next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing; the requester must re-assert start in IDLE.
- Latency: start accepted at edge E0 → RUN for cycles 1..NSLICE → done high in cycle NSLICE+1 → IDLE at cycle NSLICE+2. Minimum start-to-start spacing is NSLICE+2 cycles.
- sum and cout hold their last value until the next completion or reset. They do not change during RUN.
- Changes on a, b or cin after acceptance have no effect on the operation in flight.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is signalled only via cout.
- The slice is purely combinational. The block relies on ss/cc settling within one clock period and adds no extra wait states.

Test Plan:
- WIDTH=2, a=2'b11, b=2'b10, cin=1: the single RUN cycle drives aa1=1 aa0=1 bb1=1 bb0=0 cc0=1 → sum=2'b10, cout=1; done pulses in cycle 2.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 → cc0 sequence over 4 RUN cycles is 0,1,1,1 → sum=8'h00, cout=1, done exactly one cycle at cycle 5.
- WIDTH=8, a=8'h5A, b=8'h33, cin=1 → sum=8'h8E, cout=0. Toggling a and b during RUN leaves the result unchanged.
- start held high throughout → back-to-back operations start every 6 cycles (WIDTH=8). start pulses during RUN or DONE are ignored; busy never drops mid-operation.
- rst asserted in the second RUN cycle → next cycle: IDLE, busy=0, done=0, sum=0, cout=0, slice outputs 0. No done pulse follows.
- Randomized regression of 200 operand triples with WIDTH=8 against a behavioural reference slice model → {cout,sum} == a+b+cin on every done.

Source files
------------

// File: rtl/serial_slice_adder_ctrl.sv
// serial_slice_adder_ctrl
// Adds two WIDTH-bit operands by streaming 2-bit slices, LSB slice first,
// through an external combinational 2-bit full-adder slice, one slice per clock.
// The inter-slice carry is registered here, and the partial sums are collected
// into an accumulator.
//
// Handshake: start is sampled only in IDLE. An accepted start latches a, b and
// cin. busy is high from the cycle after acceptance through the DONE cycle.
// done pulses for one cycle, and sum/cout are valid from that cycle onward.
// sum/cout hold until the next completion or reset. start in RUN/DONE is
// dropped, not queued.
//
// WIDTH must be even and at least 2.
module serial_slice_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             aa1,
  output logic             aa0,
  output logic             bb1,
  output logic             bb0,
  output logic             cc0,
  input  logic             cc1,
  input  logic             ss1,
  input  logic             ss0
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic             last_slice;

  assign last_slice = (idx == LAST_IDX);

  // State register; reset wins even in the middle of an operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, status flags, slice drive and accumulator merge of the current slice.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    aa1        = 1'b0;
    aa0        = 1'b0;
    bb1        = 1'b0;
    bb0        = 1'b0;
    cc0        = 1'b0;
    acc_next   = acc;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        {aa1, aa0} = a_lat[2*idx +: 2];
        {bb1, bb0} = b_lat[2*idx +: 2];
        cc0        = carry_reg;
        acc_next[2*idx +: 2] = {ss1, ss0};
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, slice index, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat     <= '0;
      b_lat     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat     <= a;
            b_lat     <= b;
            carry_reg <= cin;
            idx       <= '0;
          end
        end
        RUN: begin
          acc       <= acc_next;
          carry_reg <= cc1;
          if (last_slice) begin
            // acc_next already holds the slice being added this cycle.
            sum  <= acc_next;
            cout <= cc1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
